multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait for mem_ready_i, 0 = mem_ready_i ignored and treated as 1.
REQ-002 SHALL have parameter WAIT_MAX, default 15; maximum cycles a memory state may wait before timeout, legal range 1..255.
REQ-003 SHALL have parameter OP_W, default 6; opcode width, with only the low 6 bits decoded and upper bits required to be zero.
REQ-004 One clock; reset is synchronous and active-high: clk_i  in  1  rising-edge clock.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 op_i  in  OP_W  opcode from instruction register.
REQ-007 mem_ready_i  in  1  memory access completes this cycle.
REQ-008 pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o  out  1 each  datapath strobes and selects.
REQ-009 alu_src_b_o  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended imm, 11 imm<<2.
REQ-010 alu_op_o  out  2  00 add, 01 sub, 10 or, 11 R-type funct.
REQ-011 pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-013 illegal_o, timeout_o  out  1 each  sticky fault flags.
REQ-014 state_o  out  4  current state encoding, for debug.

Function
REQ-015 SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP; all outputs not listed for a state are 0.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write = mem_ready_i; advance to DECODE on ready.
REQ-017 DECODE: alu_src_b=11, alu_op=00; SHALL register op_i into op_q; next state by op_i: 0x00 R_EXEC, 0x08/0x0D I_EXEC, 0x23/0x2B MEM_ADDR, 0x04 BRANCH, 0x02 JUMP, any other value TRAP.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_READ if op_q=0x23, else MEM_WRITE.
REQ-019 MEM_READ: mem_read=1, iord=1; go to MEM_WB on ready. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-020 MEM_WRITE: mem_write=1, iord=1; go to FETCH on ready.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=11. R_WB: reg_write=1, reg_dst=1; then FETCH.
REQ-022 I_EXEC: alu_src_a=1, alu_src_b=10; alu_op=00 for op_q=0x08, 10 for op_q=0x0D. I_WB: reg_write=1, reg_dst=0; then FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH. JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-024 instr_done_o=1 in MEM_WB, R_WB, I_WB, BRANCH, JUMP, and in MEM_WRITE on the ready cycle only.
REQ-025 Latency with zero wait states SHALL be: beq/j 3 cycles, R/addi/ori/sw 4 cycles, lw 5 cycles.
REQ-026 Wait counter SHALL clear on entry to each memory state and increment each cycle without ready; reaching WAIT_MAX SHALL move the FSM to TRAP and set timeout_o.
REQ-027 When mem_ready_i arrives on the same cycle the counter reaches WAIT_MAX, ready SHALL win and no timeout is raised.
REQ-028 With MEM_HANDSHAKE=0 the counter SHALL be inert and timeout_o SHALL stay 0.
REQ-029 TRAP SHALL be absorbing: all strobes 0, illegal_o (bad opcode) or timeout_o held at 1 until reset.

Reset
REQ-030 rst_i SHALL, at the next edge and from any state including mid-access, force FETCH, op_q=0, counter=0, illegal_o=0, timeout_o=0.
REQ-031 During and on the cycle after reset, no write strobe (pc_write, mem_write, reg_write, ir_write) SHALL assert unless FETCH sees mem_ready_i.

Structure
REQ-032 A shared package ctrl_pkg SHALL hold the state encoding, opcode constants, and ALU-op, ALU-B-select and PC-source encodings.
REQ-033 The wait counter SHALL be the sub-module mem_wait_timer (parameter WAIT_MAX, ports clear/tick/expired).

Verification
REQ-034 R-type: op=0x00, ready held 1 -> states FETCH,DECODE,R_EXEC,R_WB; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulses once.
REQ-035 lw with 2 wait cycles in MEM_READ: op=0x23 -> 7 cycles total, mem_to_reg=1 only in MEM_WB.
REQ-036 ori: op=0x0D -> alu_op=10 in I_EXEC; changing op_i to 0x08 after DECODE does not alter alu_op.
REQ-037 Illegal: op=0x3F -> TRAP after DECODE, illegal_o=1 held; rst_i then gives FETCH with flags 0.
REQ-038 Timeout: WAIT_MAX=3, ready held 0 in FETCH -> TRAP after 3 cycles, timeout_o=1; a repeat run with ready on cycle 3 gives no timeout.
REQ-039 Reset mid-MEM_WRITE: mem_write drops at the next edge and the FSM is in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcode values and the datapath select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_I_EXEC    = 4'd8,
        ST_I_WB      = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that talk to memory and therefore may stall on ready
    function automatic logic isMemState(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

    // Opcode dispatch out of DECODE; any set bit above the low six is illegal
    function automatic state_t decodeOp(input logic [5:0] op, input logic upperZero);
        state_t s;
        if (!upperZero) begin
            s = ST_TRAP;
        end else begin
            case (op)
                OP_RTYPE:       s = ST_R_EXEC;
                OP_ADDI, OP_ORI: s = ST_I_EXEC;
                OP_LW, OP_SW:   s = ST_MEM_ADDR;
                OP_BEQ:         s = ST_BRANCH;
                OP_J:           s = ST_JUMP;
                default:        s = ST_TRAP;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles inside a memory state and flags the cycle on which
// one more stall would reach the limit.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam logic [7:0] LAST_COUNT = 8'(WAIT_MAX - 1);

    logic [7:0] r_count;

    // Stall counter: cleared on reset or whenever the controller is not dwelling in a memory state
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
        end else if (tick_i) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired_o = tick_i && (r_count == LAST_COUNT);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a classic multicycle MIPS-style datapath, with
// memory-ready handshaking, a stall timeout and sticky fault flags.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_MAX      = 15,
    parameter int OP_W          = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            mem_ready_i,
    output logic            pc_write_o,
    output logic            pc_write_cond_o,
    output logic            iord_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            ir_write_o,
    output logic            mem_to_reg_o,
    output logic            reg_dst_o,
    output logic            reg_write_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic [1:0]      pc_source_o,
    output logic            instr_done_o,
    output logic            illegal_o,
    output logic            timeout_o,
    output logic [3:0]      state_o
);

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_opQ;
    logic            r_illegal;
    logic            r_timeout;
    logic            w_readyEff;
    logic            w_inMem;
    logic            w_tick;
    logic            w_clear;
    logic            w_expired;
    logic [OP_W+5:0] w_opWide;
    logic [5:0]      w_op6;
    logic            w_opUpperZero;

    assign w_opWide      = {6'd0, op_i};
    assign w_op6         = w_opWide[5:0];
    assign w_opUpperZero = ((w_opWide >> 6) == '0);

    assign w_readyEff = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
    assign w_inMem    = isMemState(r_state);
    assign w_tick     = (MEM_HANDSHAKE != 0) && w_inMem && !mem_ready_i;
    assign w_clear    = !w_inMem || (w_next != r_state);

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_waitTimer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (w_clear),
        .tick_i   (w_tick),
        .expired_o(w_expired)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched opcode and sticky fault flags, all held until reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_opQ     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_opQ <= w_op6;
            end
            if ((r_state == ST_DECODE) && (w_next == ST_TRAP)) begin
                r_illegal <= 1'b1;
            end
            if (w_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Next-state logic; ready beats expiry because expiry only fires on a stalled cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_readyEff)     w_next = ST_DECODE;
                else if (w_expired) w_next = ST_TRAP;
            end
            ST_DECODE:   w_next = decodeOp(w_op6, w_opUpperZero);
            ST_MEM_ADDR: w_next = (r_opQ == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: begin
                if (w_readyEff)     w_next = ST_MEM_WB;
                else if (w_expired) w_next = ST_TRAP;
            end
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WRITE: begin
                if (w_readyEff)     w_next = ST_FETCH;
                else if (w_expired) w_next = ST_TRAP;
            end
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_R_WB:     w_next = ST_FETCH;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_I_WB:     w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_TRAP:     w_next = ST_TRAP;
            default:     w_next = ST_TRAP;
        endcase
    end

    // Datapath controls per state; write strobes are suppressed under reset except a ready FETCH
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = ALUB_REG;
        alu_op_o        = ALUOP_ADD;
        pc_source_o     = PCSRC_ALU;
        instr_done_o    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = ALUB_FOUR;
                ir_write_o  = w_readyEff;
                pc_write_o  = w_readyEff;
            end
            ST_DECODE: begin
                alu_src_b_o = ALUB_IMMSH2;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALUB_IMM;
            end
            ST_MEM_READ: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = w_readyEff;
            end
            ST_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALUB_IMM;
                alu_op_o    = (r_opQ == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            ST_I_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                instr_done_o    = 1'b1;
            end
            ST_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PCSRC_JUMP;
                instr_done_o = 1'b1;
            end
            default: begin
            end
        endcase
        if (rst_i && (r_state != ST_FETCH)) begin
            pc_write_o  = 1'b0;
            mem_write_o = 1'b0;
            reg_write_o = 1'b0;
            ir_write_o  = 1'b0;
        end
    end

    assign illegal_o = r_illegal;
    assign timeout_o = r_timeout;
    assign state_o   = r_state;

endmodule
